// File: rtl/mem_io_pkg.sv
// mem_io_pkg: shared constants, types and the address decoder for the
// basic-computer memory / memory-mapped I/O slave. The optional
// MEM_IO_OUT_FIFO_EN macro changes how many bytes the output buffer holds.
package mem_io_pkg;

    // Word addresses of the I/O registers; everything below ADDR_INPR is RAM
    localparam logic [11:0] ADDR_INPR   = 12'hFFC;
    localparam logic [11:0] ADDR_STATUS = 12'hFFD;
    localparam logic [11:0] ADDR_OUTR   = 12'hFFE;
    localparam logic [11:0] ADDR_RSVD   = 12'hFFF;

    // Bit positions inside the STATUS word
    localparam int STAT_FGI = 0;
    localparam int STAT_FGO = 1;
    localparam int STAT_OVF = 2;

    // Output FIFO geometry (used only when the FIFO build is selected)
    localparam int OUTQ_DEPTH = 4;
    localparam int OUTQ_PTR_W = $clog2(OUTQ_DEPTH);

    // Which part of the map an address falls into
    typedef enum logic [2:0] {
        REGION_RAM,
        REGION_INPR,
        REGION_STATUS,
        REGION_OUTR,
        REGION_RSVD
    } region_e;

    // Classify a decoded 12-bit word address
    function automatic region_e decode_region(input logic [11:0] a);
        region_e r;
        case (a)
            ADDR_INPR:   r = REGION_INPR;
            ADDR_STATUS: r = REGION_STATUS;
            ADDR_OUTR:   r = REGION_OUTR;
            ADDR_RSVD:   r = REGION_RSVD;
            default:     r = REGION_RAM;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/mem_io_outq.sv
// mem_io_outq: output byte buffer behind the OUTR register.
// With MEM_IO_OUT_FIFO_EN defined it is a 4-entry circular FIFO; otherwise it
// is a single holding register whose valid bit doubles as "full".
// The parent only asserts push when there is space (not full, or popping on
// the same edge) and only asserts pop when the buffer is not empty.
module mem_io_outq
    import mem_io_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic       push,
    input  logic [7:0] push_data,
    input  logic       pop,
    output logic       full,
    output logic       empty,
    output logic [7:0] head
);

`ifdef MEM_IO_OUT_FIFO_EN

    logic [7:0]            slots [0:OUTQ_DEPTH-1];
    logic [OUTQ_PTR_W-1:0] wr_ptr;
    logic [OUTQ_PTR_W-1:0] rd_ptr;
    logic [OUTQ_PTR_W:0]   count;

    // Storage, wrapping pointers and occupancy; slots clear so out_data reads 0 after reset
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < OUTQ_DEPTH; i++) begin
                slots[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                slots[wr_ptr] <= push_data;
                wr_ptr        <= wr_ptr + OUTQ_PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + OUTQ_PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (OUTQ_PTR_W + 1)'(1);
                2'b01:   count <= count - (OUTQ_PTR_W + 1)'(1);
                default: count <= count;
            endcase
        end
    end

    assign full  = (count == (OUTQ_PTR_W + 1)'(OUTQ_DEPTH));
    assign empty = (count == '0);
    assign head  = slots[rd_ptr];

`else

    logic [7:0] outr;
    logic       valid;

    // Single OUTR register: a push (re)loads it, a pop without push empties it
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            outr  <= '0;
            valid <= 1'b0;
        end else begin
            if (push) begin
                outr  <= push_data;
                valid <= 1'b1;
            end else if (pop) begin
                valid <= 1'b0;
            end
        end
    end

    assign full  = valid;
    assign empty = ~valid;
    assign head  = outr;

`endif

endmodule

// File: rtl/mem_io.sv
// mem_io: unified RAM plus memory-mapped I/O slave for the basic computer.
// Reads are combinational; writes commit once per falling we_n (or per
// address change while we_n stays low). The top four word addresses hold
// INPR, STATUS, OUTR and a reserved slot. Define MEM_IO_OUT_FIFO_EN to give
// the output port a 4-entry FIFO instead of a single OUTR register.
module mem_io
    import mem_io_pkg::*;
#(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 16,
    parameter int MEM_AW     = 12
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  we_n,
    output logic [DATA_WIDTH-1:0] rdata,
    input  logic                  in_valid,
    input  logic [7:0]            in_data,
    output logic                  in_ready,
    output logic                  out_valid,
    output logic [7:0]            out_data,
    input  logic                  out_ready
);

    localparam int RAM_DEPTH = (2 ** MEM_AW) - 4;

    logic [DATA_WIDTH-1:0] mem [0:RAM_DEPTH-1];

    logic [MEM_AW-1:0] a;
    logic [MEM_AW-1:0] a_q;
    logic              we_q;
    logic              wr;
    region_e           region;

    logic              fgi;
    logic              ovf;
    logic [7:0]        inpr;

    logic              q_full;
    logic              q_empty;
    logic [7:0]        q_head;
    logic              q_push;
    logic              q_pop;
    logic              space;
    logic              wr_status;
    logic              wr_outr;
    logic              in_fire;

    // Upper address bits alias the low 4K; folded here so they are not flagged as dangling
    logic              unused_addr_hi;
    assign unused_addr_hi = ^addr[ADDR_WIDTH-1:MEM_AW];

    assign a      = addr[MEM_AW-1:0];
    assign region = decode_region(a);

    // Strobe only on the first cycle of a write, or when the address moves during one
    assign wr        = ~we_n & (we_q | (a != a_q));
    assign wr_status = wr & (region == REGION_STATUS);
    assign wr_outr   = wr & (region == REGION_OUTR);

    assign q_pop     = ~q_empty & out_ready;
    assign space     = ~q_full | q_pop;
    assign q_push    = wr_outr & space;

    assign in_ready  = ~fgi;
    assign in_fire   = in_valid & in_ready;

    assign out_valid = ~q_empty;
    assign out_data  = q_head;

    // Remember last cycle's bus state for write-edge detection
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            we_q <= 1'b1;
            a_q  <= '0;
        end else begin
            we_q <= we_n;
            a_q  <= a;
        end
    end

    // RAM write port; contents deliberately survive reset
    always_ff @(posedge clk) begin
        if (wr && (region == REGION_RAM)) begin
            mem[a] <= wdata;
        end
    end

    // Input register and FGI: a handshake fills INPR, a STATUS write with bit 0 empties it
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            inpr <= '0;
            fgi  <= 1'b0;
        end else begin
            if (in_fire) begin
                inpr <= in_data;
                fgi  <= 1'b1;
            end else if (wr_status && wdata[STAT_FGI]) begin
                fgi  <= 1'b0;
            end
        end
    end

    // Sticky overflow: set on a dropped OUTR byte, cleared by STATUS bit 2
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ovf <= 1'b0;
        end else begin
            if (wr_outr && !space) begin
                ovf <= 1'b1;
            end else if (wr_status && wdata[STAT_OVF]) begin
                ovf <= 1'b0;
            end
        end
    end

    mem_io_outq u_outq (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (q_push),
        .push_data (wdata[7:0]),
        .pop       (q_pop),
        .full      (q_full),
        .empty     (q_empty),
        .head      (q_head)
    );

    // Combinational read mux over RAM and the I/O registers
    always_comb begin
        rdata = '0;
        case (region)
            REGION_RAM: begin
                rdata = mem[a];
            end
            REGION_INPR: begin
                rdata[7:0] = inpr;
            end
            REGION_STATUS: begin
                rdata[STAT_FGI] = fgi;
                rdata[STAT_FGO] = ~q_full;
                rdata[STAT_OVF] = ovf;
            end
            default: begin
                rdata = '0;
            end
        endcase
    end

endmodule
